microwave_timer: RTL and testbench
==================================

// Module: microwave_timer
// PURPOSE
//  Countdown timer that pairs with the magnetron controller. It takes cook-time digits from
//  the keypad and counts them down in BCD MM:SS while mag_on is high. It drives timer_done
//  back to the magnetron control, which turns the magnetron off at zero. Its digit outputs
//  feed the 7-segment display path.
// PARAMETERS
//  TICKS_PER_SEC  100  clk cycles per 1 s countdown step (>=2; board builds use the clk freq)
//  PRESC_W        7    prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_SEC
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-high reset
//  mag_on       in   1        magnetron running (from the SR latch); enables the countdown
//  clearn       in   1        active-low synchronous clear of the entered/remaining time
//  key_valid    in   1        one-cycle strobe: key_digit is valid
//  key_digit    in   4        BCD digit from the keypad encoder
//  sec_ones     out  4        BCD seconds, units
//  sec_tens     out  4        BCD seconds, tens
//  min_ones     out  4        BCD minutes, units
//  min_tens     out  4        BCD minutes, tens
//  timer_done   out  1        registered; high when all four digits are 0
//  running      out  1        registered; high in the RUN state
// BEHAVIOUR
//  Reset (async): all digits 0, prescaler 0, state IDLE, timer_done=1, running=0.
//  FSM (registered, evaluated each clk edge; clearn has top priority):
//   IDLE : count == 00:00. Valid key -> ARMED if the result is nonzero.
//   ARMED: count != 0, mag_on=0. mag_on=1 -> RUN. Clear -> IDLE.
//   RUN  : mag_on=1 and counting. mag_on=0 -> ARMED (pause). Count reaches 0 -> IDLE.
//          clearn=0 -> IDLE.
//  Clear: when clearn=0, digits go to 0 and prescaler goes to 0 next edge, in any state.
//   This overrides a key and a tick in the same cycle.
//  Key entry: accepted only when mag_on=0, clearn=1, key_valid=1 and key_digit<=9.
//   Otherwise the key is ignored, with no state change.
//   Shift-left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
//   The oldest digit is discarded. sec_tens>5 is stored as typed (e.g. 00:90 = 90 s).
//  Prescaler: increments only while mag_on=1 and count!=0. It holds its value while paused,
//   so partial seconds are kept. A tick fires when the prescaler reaches TICKS_PER_SEC-1;
//   the prescaler then wraps to 0.
//  Decrement on tick, as a BCD borrow chain:
//   sec_ones 0 -> 9 with borrow.
//   sec_tens 0 -> 5 with borrow.
//   min_ones 0 -> 9 with borrow.
//   min_tens decrements.
//   Count never goes below 00:00. With mag_on=1 at 00:00 there is no tick and no change.
//  Latency: the first decrement occurs TICKS_PER_SEC clk edges after mag_on rises (from
//   prescaler 0). timer_done rises on the same edge that loads 00:00 (registered compare of
//   the next value). It stays high until a nonzero digit is entered.
//  Simultaneous: a key with mag_on=1 is ignored. A tick with clearn=0 is ignored (clear wins).
//  mag_on=1 with count 0: stays IDLE, running=0, timer_done=1. The magnetron latch resets.
//  Reset mid-RUN: immediate return to IDLE values; no residual tick.
// TESTING  (TICKS_PER_SEC=4)
//  1 Reset, then keys 1,3,0 -> display 01:30, timer_done=0, state ARMED. Key 0xA ignored.
//  2 Load 00:02, hold mag_on=1 -> 00:01 after 4 clks, 00:00 after 8 clks. timer_done=1 and
//    running=0 on that edge.
//  3 Load 01:00, run 4 clks -> 00:59 (borrow chain). Load 10:00, run 4 clks -> 09:59.
//  4 Pause: load 00:05, run 6 clks (one tick plus 2 in the prescaler), mag_on=0 for 20 clks
//    -> still 00:04. mag_on=1: next tick after 2 clks -> 00:03.
//  5 Run 00:09, pulse clearn=0 coincident with a tick -> 00:00 next edge, timer_done=1, IDLE.
//    Keys pressed during RUN do not alter the digits.
//  6 Assert reset mid-RUN at 05:37 -> outputs 00:00, timer_done=1, running=0 immediately.
//    Prescaler restarts from 0.

Source files
------------

// File: rtl/microwave_timer.sv
// BCD MM:SS cook timer: keypad digits shift in while the magnetron is off,
// and the count decrements once per TICKS_PER_SEC clocks while mag_on is high.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRESC_W       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mag_on,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       timer_done,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [PRESC_W-1:0] presc, presc_next;
    logic [3:0]         sec_ones_next, sec_tens_next, min_ones_next, min_tens_next;
    logic               count_zero, next_zero, key_ok, tick;

    assign count_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                        (min_ones == 4'd0) && (min_tens == 4'd0);
    assign key_ok     = key_valid && !mag_on && (key_digit <= 4'd9);
    assign tick       = mag_on && !count_zero &&
                        (presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign running    = (state == RUN);

    // Priority: clear, then key entry, then the per-second borrow chain.
    always_comb begin
        sec_ones_next = sec_ones;
        sec_tens_next = sec_tens;
        min_ones_next = min_ones;
        min_tens_next = min_tens;
        presc_next    = presc;

        if (!clearn) begin
            sec_ones_next = 4'd0;
            sec_tens_next = 4'd0;
            min_ones_next = 4'd0;
            min_tens_next = 4'd0;
            presc_next    = '0;
        end else if (key_ok) begin
            min_tens_next = min_ones;
            min_ones_next = sec_tens;
            sec_tens_next = sec_ones;
            sec_ones_next = key_digit;
        end else if (tick) begin
            presc_next = '0;
            if (sec_ones != 4'd0) begin
                sec_ones_next = sec_ones - 4'd1;
            end else begin
                sec_ones_next = 4'd9;
                if (sec_tens != 4'd0) begin
                    sec_tens_next = sec_tens - 4'd1;
                end else begin
                    sec_tens_next = 4'd5;
                    if (min_ones != 4'd0) begin
                        min_ones_next = min_ones - 4'd1;
                    end else begin
                        min_ones_next = 4'd9;
                        min_tens_next = min_tens - 4'd1;
                    end
                end
            end
        end else if (mag_on && !count_zero) begin
            presc_next = presc + PRESC_W'(1);
        end

        next_zero = (sec_ones_next == 4'd0) && (sec_tens_next == 4'd0) &&
                    (min_ones_next == 4'd0) && (min_tens_next == 4'd0);

        // The state follows the next count, so reaching zero and clearing both land in IDLE.
        if (!clearn || next_zero)
            state_next = IDLE;
        else if (mag_on)
            state_next = RUN;
        else
            state_next = ARMED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            sec_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            min_ones   <= 4'd0;
            min_tens   <= 4'd0;
            timer_done <= 1'b1;
        end else begin
            state      <= state_next;
            presc      <= presc_next;
            sec_ones   <= sec_ones_next;
            sec_tens   <= sec_tens_next;
            min_ones   <= min_ones_next;
            min_tens   <= min_tens_next;
            timer_done <= next_zero;
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Scoreboard bench for microwave_timer: stimulus queues expected MM:SS/done/running,
// a negedge monitor pops and compares each entry against the DUT.
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mag_on = 1'b0;
    logic       clearn = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       timer_done, running;

    typedef struct {
        string       name;
        logic [15:0] digits;
        logic        done;
        logic        run;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    microwave_timer #(.TICKS_PER_SEC(4), .PRESC_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .mag_on     (mag_on),
        .clearn     (clearn),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .timer_done (timer_done),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation is consumed per falling edge, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] got;
            e = exp_q.pop_front();
            got = {min_tens, min_ones, sec_tens, sec_ones};
            checks++;
            if (got !== e.digits || timer_done !== e.done || running !== e.run) begin
                errors++;
                $display("[TB] FAIL %s: got %h done=%b run=%b, expected %h done=%b run=%b",
                         e.name, got, timer_done, running, e.digits, e.done, e.run);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [15:0] digits,
                              input logic done, input logic run);
        exp_t e;
        e.name = name;
        e.digits = digits;
        e.done = done;
        e.run = run;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] t);
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        press(t[15:12]);
        press(t[11:8]);
        press(t[7:4]);
        press(t[3:0]);
    endtask

    task automatic run_steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        expect_now("reset", 16'h0000, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        step();

        // Key entry and illegal digit
        press(4'd1);  expect_now("key_1", 16'h0001, 1'b0, 1'b0);
        press(4'd3);  expect_now("key_13", 16'h0013, 1'b0, 1'b0);
        press(4'd0);  expect_now("key_130", 16'h0130, 1'b0, 1'b0);
        press(4'hA);  expect_now("key_A_ignored", 16'h0130, 1'b0, 1'b0);
        press(4'd4);
        press(4'd5);  expect_now("oldest_discarded", 16'h3045, 1'b0, 1'b0);

        // Countdown to zero, then hold at zero
        load(16'h0002);
        mag_on = 1'b1;
        run_steps(3); expect_now("run_before_tick", 16'h0002, 1'b0, 1'b1);
        step();       expect_now("first_tick", 16'h0001, 1'b0, 1'b1);
        run_steps(4); expect_now("reach_zero", 16'h0000, 1'b1, 1'b0);
        run_steps(2); expect_now("no_underflow", 16'h0000, 1'b1, 1'b0);
        mag_on = 1'b0;

        // Borrow chains
        load(16'h0100);
        mag_on = 1'b1;
        run_steps(4); expect_now("borrow_0100", 16'h0059, 1'b0, 1'b1);
        mag_on = 1'b0;
        load(16'h1000);
        mag_on = 1'b1;
        run_steps(4); expect_now("borrow_1000", 16'h0959, 1'b0, 1'b1);
        mag_on = 1'b0;
        load(16'h0090);
        mag_on = 1'b1;
        run_steps(4); expect_now("sec_tens_9", 16'h0089, 1'b0, 1'b1);
        mag_on = 1'b0;

        // Pause keeps the partial second
        load(16'h0005);
        mag_on = 1'b1;
        run_steps(6); expect_now("pause_run6", 16'h0004, 1'b0, 1'b1);
        mag_on = 1'b0;
        step();       expect_now("paused_armed", 16'h0004, 1'b0, 1'b0);
        run_steps(19); expect_now("paused_20", 16'h0004, 1'b0, 1'b0);
        mag_on = 1'b1;
        step();       expect_now("resume_1", 16'h0004, 1'b0, 1'b1);
        step();       expect_now("resume_tick", 16'h0003, 1'b0, 1'b1);
        mag_on = 1'b0;

        // Key during run ignored; clear beats a tick
        load(16'h0009);
        mag_on = 1'b1;
        run_steps(2);
        key_valid = 1'b1;
        key_digit = 4'd7;
        step();       expect_now("key_in_run", 16'h0009, 1'b0, 1'b1);
        key_valid = 1'b0;
        clearn = 1'b0;
        step();       expect_now("clear_vs_tick", 16'h0000, 1'b1, 1'b0);
        clearn = 1'b1;
        step();       expect_now("mag_on_at_zero", 16'h0000, 1'b1, 1'b0);
        mag_on = 1'b0;

        // Reset mid-run, then prescaler must restart from 0
        load(16'h0537);
        mag_on = 1'b1;
        run_steps(2);
        #2 reset = 1'b1;
        #1 expect_now("reset_mid_run", 16'h0000, 1'b1, 1'b0);
        step();
        mag_on = 1'b0;
        reset = 1'b0;
        step();
        press(4'd2);  expect_now("post_reset_key", 16'h0002, 1'b0, 1'b0);
        mag_on = 1'b1;
        run_steps(3); expect_now("presc_restart", 16'h0002, 1'b0, 1'b1);
        step();       expect_now("presc_tick", 16'h0001, 1'b0, 1'b1);
        mag_on = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
